// File: rtl/ttl_mux_registered.sv
// Registered N-block, M-input data selector with stored inputs, registered select and auto-scan.
// Optional feature: define TTL_MUX_PARITY_EN to build the registered output-parity flag.
module ttl_mux_registered #(
    parameter int unsigned BLOCKS       = 4,
    parameter int unsigned WIDTH_IN     = 4,
    parameter int unsigned WIDTH_SELECT = $clog2(WIDTH_IN),
    parameter bit          INVERT       = 1'b1,
    parameter int unsigned DELAY_RISE   = 0,
    parameter int unsigned DELAY_FALL   = 0
) (
    input  logic                         Clk,
    input  logic                         Clear,
    input  logic                         Enable_bar,
    input  logic                         Store_bar,
    input  logic                         Load_select,
    input  logic                         Auto,
    input  logic [WIDTH_SELECT-1:0]      Select,
    input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
    output logic [BLOCKS-1:0]            Y,
    output logic [WIDTH_SELECT-1:0]      Index,
    output logic                         Valid,
    output logic                         Wrap,
    output logic                         Parity
);

    localparam logic [WIDTH_SELECT-1:0] LastSel = WIDTH_SELECT'(WIDTH_IN - 1);

    logic [BLOCKS-1:0]       data_q [WIDTH_IN];
    logic [WIDTH_SELECT-1:0] sel_q;
    logic [WIDTH_SELECT-1:0] sel_d;
    logic [BLOCKS-1:0]       y_q;
    logic [BLOCKS-1:0]       y_d;
    logic [BLOCKS-1:0]       rd_word;
    logic                    valid_q;
    logic                    wrap_q;
    logic                    wrap_d;

    // Explicit compare mux keeps non-power-of-two depths free of out-of-range indexing.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < WIDTH_IN; k++) begin
            if (sel_q == WIDTH_SELECT'(k)) begin
                rd_word = data_q[k];
            end
        end
    end

    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (Load_select) begin
            sel_d = (Select <= LastSel) ? Select : '0;
        end else if (Auto) begin
            if (sel_q == LastSel) begin
                sel_d  = '0;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
        y_d = Enable_bar ? '0 : rd_word;
    end

`ifdef TTL_MUX_PARITY_EN
    logic parity_q;
`endif

    always_ff @(posedge Clk) begin
        if (Clear) begin
            for (int k = 0; k < WIDTH_IN; k++) begin
                data_q[k] <= '0;
            end
            sel_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef TTL_MUX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (!Store_bar) begin
                for (int k = 0; k < WIDTH_IN; k++) begin
                    data_q[k] <= A_2D[k*BLOCKS +: BLOCKS];
                end
            end
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= ~Enable_bar;
            wrap_q  <= wrap_d;
`ifdef TTL_MUX_PARITY_EN
            parity_q <= ^y_d;
`endif
        end
    end

`ifdef TTL_MUX_PARITY_EN
    assign Parity = parity_q;
`else
    assign Parity = 1'b0;
`endif

    assign Y     = INVERT ? ~y_q : y_q;
    assign Index = sel_q;
    assign Valid = valid_q;
    assign Wrap  = wrap_q;

endmodule

// File: tb/tb_ttl_mux_registered.sv
// Scoreboard bench: default instance (4 words, inverting) and a 3-word true-output instance.
module tb_ttl_mux_registered;

    typedef struct {
        int         dut;
        logic [3:0] y;
        logic [1:0] idx;
        logic       valid;
        logic       wrap;
        logic       par;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en_b = 1'b0;
    logic        st_b = 1'b1;
    logic        ld = 1'b0;
    logic        au = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] a = '0;

    logic [3:0] y0, y1;
    logic [1:0] idx0, idx1;
    logic       v0, v1, w0, w1, p0, p1;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ttl_mux_registered u_dut0 (
        .Clk(clk), .Clear(clr), .Enable_bar(en_b), .Store_bar(st_b), .Load_select(ld),
        .Auto(au), .Select(sel), .A_2D(a), .Y(y0), .Index(idx0), .Valid(v0), .Wrap(w0),
        .Parity(p0)
    );

    ttl_mux_registered #(.WIDTH_IN(3), .INVERT(1'b0)) u_dut1 (
        .Clk(clk), .Clear(clr), .Enable_bar(en_b), .Store_bar(st_b), .Load_select(ld),
        .Auto(au), .Select(sel), .A_2D(a[11:0]), .Y(y1), .Index(idx1), .Valid(v1), .Wrap(w1),
        .Parity(p1)
    );

    // Drive one edge's inputs and queue the outputs expected right after that edge.
    task automatic step(input logic c, input logic eb, input logic sb, input logic l,
                        input logic au_i, input logic [1:0] s, input logic [15:0] a_i,
                        input int dut, input logic [3:0] ey, input logic [1:0] ei,
                        input logic ev, input logic ew, input string nm);
        exp_t       e;
        logic [3:0] raw;
        @(negedge clk);
        clr = c; en_b = eb; st_b = sb; ld = l; au = au_i; sel = s; a = a_i;
        raw = (dut == 0) ? ~ey : ey;
        e.dut = dut; e.y = ey; e.idx = ei; e.valid = ev; e.wrap = ew; e.name = nm;
`ifdef TTL_MUX_PARITY_EN
        e.par = ^raw;
`else
        e.par = 1'b0;
`endif
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] ay;
        logic [1:0] ai;
        logic       av, aw, ap;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    ay = y0; ai = idx0; av = v0; aw = w0; ap = p0;
                end else begin
                    ay = y1; ai = idx1; av = v1; aw = w1; ap = p1;
                end
                checks++;
                if (ay !== e.y || ai !== e.idx || av !== e.valid || aw !== e.wrap ||
                    ap !== e.par) begin
                    errors++;
                    $display("FAIL %s dut%0d: got Y=%h Index=%0d Valid=%b Wrap=%b Parity=%b, want Y=%h Index=%0d Valid=%b Wrap=%b Parity=%b",
                             e.name, e.dut, ay, ai, av, aw, ap,
                             e.y, e.idx, e.valid, e.wrap, e.par);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        // clr eb sb ld au sel a dut | Y idx V W
        step(1, 0, 0, 1, 1, 2'd3, 16'hFFFF, 0, 4'hF, 2'd0, 0, 0, "reset");
        step(0, 0, 0, 1, 0, 2'd1, 16'hDCBA, 0, 4'hF, 2'd1, 1, 0, "store_load");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 0, 4'h4, 2'd1, 1, 0, "word1_out");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 0, 4'h4, 2'd1, 1, 0, "store_hold");
        step(0, 0, 1, 1, 0, 2'd2, 16'h0000, 0, 4'h4, 2'd2, 1, 0, "sel_latency");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 0, 4'h3, 2'd2, 1, 0, "word2_out");
        step(0, 0, 1, 1, 0, 2'd0, 16'h0000, 0, 4'h3, 2'd0, 1, 0, "sel0_load");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'h5, 2'd1, 1, 0, "scan_a");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'h4, 2'd2, 1, 0, "scan_b");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'h3, 2'd3, 1, 0, "scan_c");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'h2, 2'd0, 1, 1, "scan_wrap");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'h5, 2'd1, 1, 0, "scan_again");
        step(0, 1, 1, 0, 1, 2'd0, 16'h0000, 0, 4'hF, 2'd2, 0, 0, "disable_1");
        step(0, 1, 1, 0, 1, 2'd0, 16'h0000, 0, 4'hF, 2'd3, 0, 0, "disable_2");
        step(0, 0, 1, 1, 1, 2'd1, 16'h0000, 0, 4'h2, 2'd1, 1, 0, "load_over_auto");
        step(0, 0, 0, 0, 1, 2'd0, 16'h1234, 0, 4'h4, 2'd2, 1, 0, "store_with_auto");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'hD, 2'd3, 1, 0, "new_word2");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 0, 4'hE, 2'd3, 1, 0, "new_word3");
        step(1, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'hF, 2'd0, 0, 0, "clear_mid_scan");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 0, 4'hF, 2'd1, 1, 0, "scan_restart");
        // Three-word, true-output instance
        step(1, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 4'h0, 2'd0, 0, 0, "w3_reset");
        step(0, 0, 0, 1, 0, 2'd2, 16'h0B5C, 1, 4'h0, 2'd2, 1, 0, "w3_store");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 4'hB, 2'd2, 1, 0, "w3_word_b");
        step(0, 0, 1, 1, 0, 2'd0, 16'h0000, 1, 4'hB, 2'd0, 1, 0, "w3_sel0");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 4'hC, 2'd0, 1, 0, "w3_word_c");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 1, 4'hC, 2'd1, 1, 0, "w3_scan_1");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 1, 4'h5, 2'd2, 1, 0, "w3_scan_2");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 1, 4'hB, 2'd0, 1, 1, "w3_wrap");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 1, 4'hC, 2'd1, 1, 0, "w3_after_wrap");
        step(0, 0, 1, 0, 1, 2'd0, 16'h0000, 1, 4'h5, 2'd2, 1, 0, "w3_scan_3");
        step(1, 0, 0, 0, 1, 2'd0, 16'h0FFF, 1, 4'h0, 2'd0, 0, 0, "w3_clear_store");
        step(0, 0, 1, 1, 0, 2'd2, 16'h0000, 1, 4'h0, 2'd2, 1, 0, "w3_sel2");
        step(0, 0, 1, 1, 0, 2'd3, 16'h0000, 1, 4'h0, 2'd0, 1, 0, "w3_sel_range");
        step(0, 0, 0, 0, 0, 2'd0, 16'h000A, 1, 4'h0, 2'd0, 1, 0, "w3_store_a");
        step(0, 0, 1, 0, 0, 2'd0, 16'h0000, 1, 4'hA, 2'd0, 1, 0, "w3_word_a");

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
